// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads to
// instruction memory and hands {ir, pc} pairs to the decoder through a small FIFO.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSN  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_ir,
    output logic [31:0] id_pc
);
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t          r_state;
    logic [31:0]     r_pc;
    logic [31:0]     r_pend_addr;
    logic [31:0]     r_infl_addr;
    logic            r_pending;
    logic            r_stale;
    logic            r_inflight;
    logic            r_drop;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_ir_mem [BUF_DEPTH];
    logic [31:0]     r_pc_mem [BUF_DEPTH];

    logic            w_run;
    logic            w_rsp;
    logic            w_flush;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_can_issue;
    logic [CW:0]     w_occ;
    logic            w_space;
    logic            w_req;
    logic [31:0]     w_addr;
    logic            w_fire;
    logic            w_fire_drop;
    logic            w_unused;

    assign w_unused    = ^redirect_pc[1:0];
    assign w_run       = (r_state == ST_RUN);
    // rvalid is meaningful only while a granted request is outstanding
    assign w_rsp       = r_inflight && imem_rvalid;
    assign w_flush     = redirect || halt;
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && id_ready;
    assign w_push      = w_rsp && !r_drop && !w_flush;
    assign w_can_issue = !r_inflight || imem_rvalid;

    // Occupancy after this cycle's pop and the returning word is written; a new
    // request may only go out if its word is guaranteed a free slot.
    assign w_occ   = {1'b0, r_count} + (CW+1)'(w_rsp && !r_drop) - (CW+1)'(w_pop);
    assign w_space = (w_occ < (CW+1)'(BUF_DEPTH));

    assign w_req       = rst_n && (r_pending || (w_run && !redirect && w_can_issue && w_space));
    assign w_addr      = r_pending ? r_pend_addr : r_pc;
    assign w_fire      = w_req && imem_gnt;
    // A grant in a flush cycle, or of a request left over from a flush, returns dead data
    assign w_fire_drop = w_flush || r_stale || !w_run;

    assign imem_req  = w_req;
    assign imem_addr = w_addr;
    assign id_valid  = w_valid;
    assign id_ir     = w_valid ? r_ir_mem[r_rd_ptr] : NOP_INSN;
    assign id_pc     = w_valid ? r_pc_mem[r_rd_ptr] : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_pend_addr <= RESET_PC;
            r_infl_addr <= RESET_PC;
            r_pending   <= 1'b0;
            r_stale     <= 1'b0;
            r_inflight  <= 1'b0;
            r_drop      <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (redirect) begin
                r_state <= ST_RUN;
            end else if (halt) begin
                r_state <= ST_HALTED;
            end

            if (redirect) begin
                r_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_fire && !r_stale) begin
                r_pc <= r_pc + 32'd4;
            end

            // An ungranted request stays on the bus; a flush only marks it stale
            r_pending   <= w_req && !imem_gnt;
            r_pend_addr <= w_addr;
            r_stale     <= w_req && !imem_gnt && (r_stale || w_flush);

            if (w_fire) begin
                r_inflight  <= 1'b1;
                r_infl_addr <= w_addr;
            end else if (w_rsp) begin
                r_inflight <= 1'b0;
            end

            if (w_fire) begin
                r_drop <= w_fire_drop;
            end else if (w_flush) begin
                r_drop <= r_inflight && !imem_rvalid;
            end else if (w_rsp) begin
                r_drop <= 1'b0;
            end

            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ir_mem[r_wr_ptr] <= imem_rdata;
            r_pc_mem[r_wr_ptr] <= r_infl_addr;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table drives the decoder and
// memory-side controls while a latency-programmable memory model answers requests.
module tb_fetch_stage;
    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_ir;
    logic [31:0] id_pc;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mem_t;
    mem_t mq[$];

    typedef struct {
        logic        rdy;
        logic        gnt;
        logic        redir;
        logic        hlt;
        logic [31:0] rpc;
        int          lt;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
    } vec_t;
    vec_t vq[$];

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_ir       (id_ir),
        .id_pc       (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_0000;
    endfunction

    // Memory: capture grants mid-cycle, return data lat cycles later, in order
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req && imem_gnt) mq.push_back('{cyc + lat, imem_addr});
            @(posedge clk);
            #1;
            cyc++;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (mq.size() > 0 && mq[0].due == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(mq[0].addr);
                void'(mq.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ereq, input logic [31:0] eaddr,
                           input logic evalid, input logic [31:0] epc);
        chk({tag, ".req"},   {31'b0, imem_req}, {31'b0, ereq});
        chk({tag, ".addr"},  imem_addr, eaddr);
        chk({tag, ".valid"}, {31'b0, id_valid}, {31'b0, evalid});
        chk({tag, ".pc"},    id_pc, evalid ? epc : 32'h0);
        chk({tag, ".ir"},    id_ir, evalid ? memf(epc) : NOP);
        $display("%s req=%0b addr=%08h valid=%0b pc=%08h ir=%08h",
                 tag, imem_req, imem_addr, id_valid, id_pc, id_ir);
    endtask

    task automatic add(input logic rdy, input logic gnt, input logic redir, input logic hlt,
                       input logic [31:0] rpc, input int lt, input logic ereq,
                       input logic [31:0] eaddr, input logic evalid, input logic [31:0] epc);
        vq.push_back('{rdy, gnt, redir, hlt, rpc, lt, ereq, eaddr, evalid, epc});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //  rdy gnt red hlt rpc           lat req addr          val pc
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_0000, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_0004, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_0008, 1, 32'h0000_0000);
        add(0, 1, 0, 0, 32'h0,          1, 0, 32'h0000_000C, 1, 32'h0000_0004);
        add(0, 1, 0, 0, 32'h0,          1, 0, 32'h0000_000C, 1, 32'h0000_0004);
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_000C, 1, 32'h0000_0004);
        add(1, 0, 0, 0, 32'h0,          1, 1, 32'h0000_0010, 1, 32'h0000_0008);
        add(1, 0, 0, 0, 32'h0,          1, 1, 32'h0000_0010, 1, 32'h0000_000C);
        add(1, 0, 0, 0, 32'h0,          1, 1, 32'h0000_0010, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_0010, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_0014, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_0018, 1, 32'h0000_0010);
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_001C, 1, 32'h0000_0014);
        add(1, 1, 0, 0, 32'h0,          2, 1, 32'h0000_0020, 1, 32'h0000_0018);
        add(1, 1, 1, 0, 32'h0000_0102,  2, 0, 32'h0000_0024, 1, 32'h0000_001C);
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_0100, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_0104, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_0108, 1, 32'h0000_0100);
        add(1, 1, 0, 1, 32'h0,          1, 1, 32'h0000_010C, 1, 32'h0000_0104);
        add(1, 1, 0, 0, 32'h0,          1, 0, 32'h0000_0110, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,          1, 0, 32'h0000_0110, 0, 32'h0);
        add(1, 1, 1, 0, 32'h0000_0200,  1, 0, 32'h0000_0110, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_0200, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,          1, 1, 32'h0000_0204, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,          3, 1, 32'h0000_0208, 1, 32'h0000_0200);

        rst_n       = 1'b0;
        imem_gnt    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        id_ready    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n       = 1'b1;
            id_ready    = vq[i].rdy;
            imem_gnt    = vq[i].gnt;
            redirect    = vq[i].redir;
            halt        = vq[i].hlt;
            redirect_pc = vq[i].rpc;
            lat         = vq[i].lt;
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vq[i].ereq, vq[i].eaddr, vq[i].evalid, vq[i].epc);
        end

        // Reset while the 0x208 read is outstanding; its data returns after release
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        redirect = 1'b0;
        halt     = 1'b0;
        #1;
        chk_out("rst_mid", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        imem_gnt = 1'b0;
        lat      = 1;
        @(negedge clk);
        chk_out("rel0", 1'b1, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_out("stale", 1'b1, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        imem_gnt = 1'b1;
        @(negedge clk);
        chk_out("rel_gnt", 1'b1, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_out("rel_nxt", 1'b1, 32'h4, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_out("rel_out", 1'b1, 32'h8, 1'b1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
